b64_stream_ctrl: RTL and testbench

Byte-stream scheduler for the base64 encoder in the UART IoT path. Accepts raw payload bytes from the UART RX side over a valid/ready handshake and packs them into 24-bit groups. Sequences one encode per group through the encoder sub-module and streams the four resulting ASCII characters to the UART TX side, with end-of-message `=` padding. Sits between the RX byte FIFO and the TX byte serializer.

---
 rtl/b64_pkg.sv | 27 ++
 rtl/b64_enc_core.sv | 30 +++
 rtl/b64_stream_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_b64_stream_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/b64_pkg.sv
// Shared types and constants for the base64 stream controller and its encoder core.
// Optional line breaking: compile with B64_LINE_BREAK_EN to enable the BREAK state.
package b64_pkg;

`ifdef B64_LINE_BREAK_EN
   typedef enum logic [1:0] {ST_COLLECT, ST_ENCODE, ST_EMIT, ST_BREAK} state_t;
`else
   typedef enum logic [1:0] {ST_COLLECT, ST_ENCODE, ST_EMIT} state_t;
`endif

   localparam logic [7:0] PAD_CHAR     = 8'h3D;
   localparam logic [7:0] CR_CHAR      = 8'h0D;
   localparam logic [7:0] LF_CHAR      = 8'h0A;
   localparam int         LINE_LEN_DEF = 76;

   // Maps one 6-bit sextet onto the standard base64 alphabet.
   function automatic logic [7:0] b64_char(input logic [5:0] v);
      logic [7:0] w;
      w = {2'b00, v};
      if (v < 6'd26)       return 8'h41 + w;
      else if (v < 6'd52)  return 8'h61 + w - 8'd26;
      else if (v < 6'd62)  return 8'h30 + w - 8'd52;
      else if (v == 6'd62) return 8'h2B;
      else                 return 8'h2F;
   endfunction

endpackage

// File: rtl/b64_enc_core.sv
// 24-bit group to four base64 ASCII characters; ENC_LAT registered stages, no handshake.
module b64_enc_core
   import b64_pkg::*;
#(
   parameter int ENC_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] din,
   output logic [31:0] dout
);

   logic [31:0] w_map;
   logic [31:0] r_stage [ENC_LAT];

   assign w_map = {b64_char(din[23:18]), b64_char(din[17:12]),
                   b64_char(din[11:6]),  b64_char(din[5:0])};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENC_LAT; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= w_map;
         for (int i = 1; i < ENC_LAT; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign dout = r_stage[ENC_LAT-1];

endmodule

// File: rtl/b64_stream_ctrl.sv
// Packs payload bytes into 24-bit groups, encodes each and streams four characters with '=' padding.
// B64_LINE_BREAK_EN inserts CR/LF every LINE_LEN characters (never after the final one).
module b64_stream_ctrl
   import b64_pkg::*;
#(
   parameter int ENC_LAT  = 1,
   parameter int LINE_LEN = LINE_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       busy
);

   if (ENC_LAT < 1 || ENC_LAT > 3) begin : g_bad_lat
      $error("ENC_LAT must be 1..3");
   end
   if (LINE_LEN < 4 || (LINE_LEN % 4) != 0) begin : g_bad_line
      $error("LINE_LEN must be a multiple of 4 and at least 4");
   end

   state_t      r_state, w_state_d;
   logic [1:0]  r_bcnt;
   logic [23:0] r_grp, w_grp_d;
   logic [1:0]  r_npad;
   logic        r_grp_last;
   logic [1:0]  r_enc_cnt;
   logic [31:0] r_char;
   logic [1:0]  r_cidx;
   logic [31:0] w_enc_dout;
   logic [7:0]  w_sel;
   logic        w_accept, w_grp_done, w_enc_done, w_out_acc, w_is_pad;

`ifdef B64_LINE_BREAK_EN
   localparam int LC_W = $clog2(LINE_LEN + 1);
   logic [LC_W-1:0] r_line_cnt;
   logic            r_brk_lf;
   logic            r_brk_end;
   logic            w_line_hit;
   assign w_line_hit = (r_line_cnt == LC_W'(LINE_LEN - 1));
`endif

   assign in_ready   = rst_n && (r_state == ST_COLLECT);
   assign busy       = (r_state != ST_COLLECT) || (r_bcnt != 2'd0);
   assign w_accept   = in_valid && in_ready;
   assign w_grp_done = w_accept && ((r_bcnt == 2'd2) || in_last);
   assign w_enc_done = (r_enc_cnt == 2'(ENC_LAT - 1));
   assign w_out_acc  = out_valid && out_ready;
   assign w_is_pad   = ({1'b0, r_cidx} >= (3'd4 - {1'b0, r_npad}));

   // Byte 0 zeroes the rest so short groups carry zero fill into the encoder.
   always_comb begin
      w_grp_d = r_grp;
      if (w_accept) begin
         case (r_bcnt)
            2'd0:    w_grp_d = {in_data, 16'h0000};
            2'd1:    w_grp_d = {r_grp[23:16], in_data, 8'h00};
            default: w_grp_d = {r_grp[23:8], in_data};
         endcase
      end
   end

   // Fed from the D side of the group register so the encoder starts on the closing accept edge.
   b64_enc_core #(.ENC_LAT(ENC_LAT)) u_enc (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (w_grp_d),
      .dout  (w_enc_dout)
   );

   always_comb begin
      case (r_cidx)
         2'd0:    w_sel = r_char[31:24];
         2'd1:    w_sel = r_char[23:16];
         2'd2:    w_sel = r_char[15:8];
         default: w_sel = r_char[7:0];
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      case (r_state)
         ST_EMIT: begin
            out_valid = 1'b1;
            out_data  = w_is_pad ? PAD_CHAR : w_sel;
            out_last  = r_grp_last && (r_cidx == 2'd3);
         end
`ifdef B64_LINE_BREAK_EN
         ST_BREAK: begin
            out_valid = 1'b1;
            out_data  = r_brk_lf ? LF_CHAR : CR_CHAR;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_COLLECT: if (w_grp_done) w_state_d = ST_ENCODE;
         ST_ENCODE:  if (w_enc_done) w_state_d = ST_EMIT;
         ST_EMIT: begin
            if (w_out_acc) begin
`ifdef B64_LINE_BREAK_EN
               if (w_line_hit && !out_last) w_state_d = ST_BREAK;
               else if (r_cidx == 2'd3)     w_state_d = ST_COLLECT;
`else
               if (r_cidx == 2'd3) w_state_d = ST_COLLECT;
`endif
            end
         end
`ifdef B64_LINE_BREAK_EN
         ST_BREAK: begin
            if (w_out_acc && r_brk_lf) w_state_d = r_brk_end ? ST_COLLECT : ST_EMIT;
         end
`endif
         default: w_state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_COLLECT;
         r_bcnt     <= 2'd0;
         r_grp      <= '0;
         r_npad     <= 2'd0;
         r_grp_last <= 1'b0;
         r_enc_cnt  <= 2'd0;
         r_char     <= '0;
         r_cidx     <= 2'd0;
`ifdef B64_LINE_BREAK_EN
         r_line_cnt <= '0;
         r_brk_lf   <= 1'b0;
         r_brk_end  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         if (w_accept) begin
            r_grp <= w_grp_d;
            if (w_grp_done) begin
               r_bcnt     <= 2'd0;
               r_npad     <= 2'd2 - r_bcnt;
               r_grp_last <= in_last;
            end else begin
               r_bcnt <= r_bcnt + 2'd1;
            end
         end
         if (r_state == ST_ENCODE) begin
            if (w_enc_done) begin
               r_enc_cnt <= 2'd0;
               r_char    <= w_enc_dout;
               r_cidx    <= 2'd0;
            end else begin
               r_enc_cnt <= r_enc_cnt + 2'd1;
            end
         end
         if (r_state == ST_EMIT && w_out_acc) begin
            r_cidx <= r_cidx + 2'd1;
`ifdef B64_LINE_BREAK_EN
            if (out_last) begin
               r_line_cnt <= '0;
            end else begin
               r_line_cnt <= r_line_cnt + 1'b1;
               r_brk_lf   <= 1'b0;
               r_brk_end  <= (r_cidx == 2'd3);
            end
`endif
         end
`ifdef B64_LINE_BREAK_EN
         if (r_state == ST_BREAK && w_out_acc) begin
            if (!r_brk_lf) r_brk_lf <= 1'b1;
            else           r_line_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_b64_stream_ctrl.sv
// Directed bench for b64_stream_ctrl: table of single-group messages plus stall, reset and line-break sequences.
module tb_b64_stream_ctrl;
   localparam int ENC_LAT  = 1;
   localparam int LINE_LEN = 76;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_last, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, out_last, busy;
   logic [7:0] out_data;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   b64_stream_ctrl #(.ENC_LAT(ENC_LAT), .LINE_LEN(LINE_LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy)
   );

   typedef struct {
      logic [23:0] bytes;
      int          n;
      logic        lst;
      logic [31:0] chars;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) check("send in_ready timeout", 0, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic recv(input logic [7:0] ed, input logic el, input string nm);
      int n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({nm, " valid"}, out_valid, 1);
      check({nm, " data"}, out_data, ed);
      check({nm, " last"}, out_last, el);
      if (out_valid) step();
   endtask

`ifdef B64_LINE_BREAK_EN
   task automatic run_zeros(input int nbytes, input string nm);
      int cnt = 0;
      for (int g = 0; g < nbytes / 3; g++) begin
         for (int k = 0; k < 3; k++) send_byte(8'h00, (g * 3 + k) == nbytes - 1);
         for (int c = 0; c < 4; c++) begin
            logic fin;
            fin = (g == nbytes / 3 - 1) && (c == 3);
            recv(8'h41, fin, nm);
            cnt++;
            if (cnt == LINE_LEN && !fin) begin
               recv(8'h0D, 1'b0, {nm, " cr"});
               recv(8'h0A, 1'b0, {nm, " lf"});
               cnt = 0;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         check({nm, " no trailing"}, out_valid, 0);
         step();
      end
   endtask
`endif

   initial begin
      logic [31:0] exp;
      logic [8:0]  held;
      logic        held_vld;
      int          idx, cyc;

      vecs[0] = '{24'h4D616E, 3, 1'b1, 32'h54574675};
      vecs[1] = '{24'h4D6100, 2, 1'b1, 32'h5457453D};
      vecs[2] = '{24'h4D0000, 1, 1'b1, 32'h54513D3D};
      vecs[3] = '{24'h616263, 3, 1'b1, 32'h59574A6A};
      vecs[4] = '{24'hFFFFFF, 3, 1'b1, 32'h2F2F2F2F};
      vecs[5] = '{24'h000000, 3, 1'b1, 32'h41414141};
      vecs[6] = '{24'hFBFF00, 2, 1'b1, 32'h2B2F383D};
      vecs[7] = '{24'h616263, 3, 1'b0, 32'h59574A6A};
      vecs[8] = '{24'h4D0000, 1, 1'b1, 32'h54513D3D};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
      step();
      step();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_last", out_last, 0);
      check("reset busy", busy, 0);
      check("reset in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", in_ready, 1);

      for (int v = 0; v < 9; v++) begin
         for (int k = 0; k < vecs[v].n; k++) begin
            logic [23:0] b;
            b = vecs[v].bytes;
            send_byte(b[23 - 8 * k -: 8], vecs[v].lst && (k == vecs[v].n - 1));
         end
         check($sformatf("v%0d in_ready in encode", v), in_ready, 0);
         check($sformatf("v%0d busy in encode", v), busy, 1);
         for (int c = 0; c < ENC_LAT; c++) begin
            check($sformatf("v%0d latency", v), out_valid, 0);
            step();
         end
         check($sformatf("v%0d first valid", v), out_valid, 1);
         exp = vecs[v].chars;
         for (int c = 0; c < 4; c++)
            recv(exp[31 - 8 * c -: 8], vecs[v].lst && (c == 3), $sformatf("v%0d c%0d", v, c));
         check($sformatf("v%0d in_ready after", v), in_ready, 1);
         check($sformatf("v%0d busy after", v), busy, 0);
      end

      // Random out_ready stalls: data must hold and input stays blocked until the last char goes.
      send_byte(8'h4D, 1'b0);
      send_byte(8'h61, 1'b0);
      send_byte(8'h6E, 1'b1);
      exp = 32'h54574675;
      idx = 0; cyc = 0; held_vld = 1'b0; held = '0;
      while (idx < 4 && cyc < 200) begin
         out_ready = 1'($urandom_range(0, 1));
         #1;
         check("stall in_ready", in_ready, 0);
         if (held_vld) begin
            check("stall valid held", out_valid, 1);
            check("stall data held", {out_last, out_data}, held);
         end
         if (out_valid) begin
            if (out_ready) begin
               check("stall data", out_data, exp[31 - 8 * idx -: 8]);
               check("stall last", out_last, idx == 3);
               idx++;
               held_vld = 1'b0;
            end else begin
               held_vld = 1'b1;
               held = {out_last, out_data};
            end
         end
         step();
         cyc++;
      end
      check("stall all chars", idx, 4);
      out_ready = 1'b1;
      check("stall in_ready after", in_ready, 1);

      // Reset after two characters: the rest of the group must vanish.
      send_byte(8'h4D, 1'b0);
      send_byte(8'h61, 1'b0);
      send_byte(8'h6E, 1'b1);
      recv(8'h54, 1'b0, "prerst c0");
      recv(8'h57, 1'b0, "prerst c1");
      rst_n = 1'b0;
      #1;
      check("in reset in_ready", in_ready, 0);
      step();
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst busy", busy, 0);
      rst_n = 1'b1;
      #1;
      check("after rst busy", busy, 0);
      check("after rst in_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         check("after rst idle", out_valid, 0);
         step();
      end
      send_byte(8'h4D, 1'b0);
      send_byte(8'h61, 1'b1);
      recv(8'h54, 1'b0, "postrst c0");
      recv(8'h57, 1'b0, "postrst c1");
      recv(8'h45, 1'b0, "postrst c2");
      recv(8'h3D, 1'b1, "postrst c3");

`ifdef B64_LINE_BREAK_EN
      run_zeros(60, "lb60");
      run_zeros(57, "lb57");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
